// File: rtl/pattern_err_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pattern_err_ctrl
// Purpose  : Pattern-checker error capture sequencer. Selects the failing
//            stage on the error mux, latches the expected/seen pair and hands
//            it to slow-control readout. Also keeps saturating error counts.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_err_ctrl #(
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYC    = 1,
  parameter int STOP_ON_FIRST = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              arm,
  input  logic [3:0]        chk_valid,
  input  logic [3:0]        chk_mismatch,
  input  logic [63:0]       err_expc_in,
  input  logic [63:0]       err_seen_in,
  input  logic              cap_ack,
  output logic [1:0]        err_sel,
  output logic              hold_req,
  output logic              cap_valid,
  output logic [1:0]        cap_stage,
  output logic [63:0]       cap_expc,
  output logic [63:0]       cap_seen,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              cnt_sat,
  output logic              err_lost,
  output logic              busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_SELECT = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CNT_W-1:0] c_cnt_max     = '1;
  localparam logic [3:0]       c_settle_load = 4'(SETTLE_CYC - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [3:0]        r_settle;
  logic [1:0]        r_err_sel;
  logic [1:0]        r_cap_stage;
  logic [63:0]       r_cap_expc;
  logic [63:0]       r_cap_seen;
  logic [CNT_W-1:0]  r_err_cnt;
  logic              r_cnt_sat;
  logic              r_err_lost;

  logic [3:0]        w_hit;
  logic              w_any_hit;
  logic [2:0]        w_pop;
  logic [1:0]        w_sel;
  logic [CNT_W+2:0]  w_cnt_sum;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_busy;
  logic              w_capture;
  logic              w_sample;

  assign w_hit     = chk_valid & chk_mismatch;
  assign w_any_hit = |w_hit;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < 4; i++) begin
      w_pop = w_pop + {2'b00, w_hit[i]};
    end
  end

  // Lowest set bit wins, so evt outranks the later stages.
  always_comb begin
    w_sel = 2'd3;
    if (w_hit[2]) w_sel = 2'd2;
    if (w_hit[1]) w_sel = 2'd1;
    if (w_hit[0]) w_sel = 2'd0;
  end

  assign w_cnt_sum = {3'b000, r_err_cnt} + (CNT_W+3)'(w_pop);
  assign w_cnt_nxt = (w_cnt_sum[CNT_W+2:CNT_W] != 3'b000) ? c_cnt_max
                                                           : w_cnt_sum[CNT_W-1:0];

  assign w_busy    = (r_state == S_SELECT) || (r_state == S_HOLD) || (r_state == S_DONE);
  assign w_capture = (r_state == S_ARMED) && arm && w_any_hit;
  assign w_sample  = (r_state == S_SELECT) && (r_settle == 4'd0);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else if (clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (arm) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (!arm)           w_state_nxt = S_IDLE;
        else if (w_any_hit) w_state_nxt = S_SELECT;
      end
      S_SELECT: begin
        if (w_sample) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (cap_ack) begin
          if (STOP_ON_FIRST != 0) w_state_nxt = S_DONE;
          else if (arm)           w_state_nxt = S_ARMED;
          else                    w_state_nxt = S_IDLE;
        end
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    hold_req  = (r_state == S_SELECT);
    cap_valid = (r_state == S_HOLD);
    busy      = w_busy;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_settle    <= '0;
      r_err_sel   <= '0;
      r_cap_stage <= '0;
      r_cap_expc  <= '0;
      r_cap_seen  <= '0;
      r_err_cnt   <= '0;
      r_cnt_sat   <= 1'b0;
      r_err_lost  <= 1'b0;
    end else if (clear) begin
      r_settle    <= '0;
      r_err_sel   <= '0;
      r_cap_stage <= '0;
      r_cap_expc  <= '0;
      r_cap_seen  <= '0;
      r_err_cnt   <= '0;
      r_cnt_sat   <= 1'b0;
      r_err_lost  <= 1'b0;
    end else begin
      if (arm) begin
        r_err_cnt <= w_cnt_nxt;
        if (w_cnt_nxt == c_cnt_max) r_cnt_sat <= 1'b1;
      end
      // A hit that arrives while a capture is in flight or parked is dropped.
      if (arm && w_any_hit && w_busy) r_err_lost <= 1'b1;
      if (w_capture) begin
        r_err_sel   <= w_sel;
        r_cap_stage <= w_sel;
        r_settle    <= c_settle_load;
      end
      if (r_state == S_SELECT) begin
        if (w_sample) begin
          r_cap_expc <= err_expc_in;
          r_cap_seen <= err_seen_in;
        end else begin
          r_settle <= r_settle - 4'd1;
        end
      end
    end
  end

  assign err_sel   = r_err_sel;
  assign cap_stage = r_cap_stage;
  assign cap_expc  = r_cap_expc;
  assign cap_seen  = r_cap_seen;
  assign err_cnt   = r_err_cnt;
  assign cnt_sat   = r_cnt_sat;
  assign err_lost  = r_err_lost;

endmodule
`default_nettype wire

// File: tb/tb_pattern_err_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_err_ctrl
// Purpose  : Directed bench for pattern_err_ctrl; instance a uses the default
//            parameters, instance b uses CNT_W=4, SETTLE_CYC=3, STOP_ON_FIRST=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_err_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        arm;
  logic [3:0]  chk_valid;
  logic [3:0]  chk_mismatch;
  logic [63:0] err_expc_in;
  logic [63:0] err_seen_in;
  logic        cap_ack;

  logic [1:0]  a_err_sel, a_cap_stage;
  logic        a_hold_req, a_cap_valid, a_cnt_sat, a_err_lost, a_busy;
  logic [63:0] a_cap_expc, a_cap_seen;
  logic [15:0] a_err_cnt;

  logic [1:0]  b_err_sel, b_cap_stage;
  logic        b_hold_req, b_cap_valid, b_cnt_sat, b_err_lost, b_busy;
  logic [63:0] b_cap_expc, b_cap_seen;
  logic [3:0]  b_err_cnt;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  pattern_err_ctrl u_dut_a (
    .clk(clk), .reset_n(reset_n), .clear(clear), .arm(arm),
    .chk_valid(chk_valid), .chk_mismatch(chk_mismatch),
    .err_expc_in(err_expc_in), .err_seen_in(err_seen_in), .cap_ack(cap_ack),
    .err_sel(a_err_sel), .hold_req(a_hold_req), .cap_valid(a_cap_valid),
    .cap_stage(a_cap_stage), .cap_expc(a_cap_expc), .cap_seen(a_cap_seen),
    .err_cnt(a_err_cnt), .cnt_sat(a_cnt_sat), .err_lost(a_err_lost), .busy(a_busy)
  );

  pattern_err_ctrl #(.CNT_W(4), .SETTLE_CYC(3), .STOP_ON_FIRST(1)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .clear(clear), .arm(arm),
    .chk_valid(chk_valid), .chk_mismatch(chk_mismatch),
    .err_expc_in(err_expc_in), .err_seen_in(err_seen_in), .cap_ack(cap_ack),
    .err_sel(b_err_sel), .hold_req(b_hold_req), .cap_valid(b_cap_valid),
    .cap_stage(b_cap_stage), .cap_expc(b_cap_expc), .cap_seen(b_cap_seen),
    .err_cnt(b_err_cnt), .cnt_sat(b_cnt_sat), .err_lost(b_err_lost), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hit(input logic [3:0] v, input logic [3:0] m);
    chk_valid    = v;
    chk_mismatch = m;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; clear = 1'b0; arm = 1'b0; cap_ack = 1'b0;
    set_hit(4'b0000, 4'b0000);
    err_expc_in = 64'hAAAA_AAAA_AAAA_AAAA;
    err_seen_in = 64'h5555_5555_5555_5555;

    // Reset state
    step();
    check("rst_err_sel",  a_err_sel,   0);
    check("rst_hold_req", a_hold_req,  0);
    check("rst_cap_valid",a_cap_valid, 0);
    check("rst_err_cnt",  a_err_cnt,   0);
    check("rst_busy",     a_busy,      0);
    check("rst_b_expc",   b_cap_expc,  0);

    // Single evt mismatch, default settle of 1
    reset_n = 1'b1; arm = 1'b1;
    step();
    set_hit(4'b0001, 4'b0001);
    step();
    set_hit(4'b0000, 4'b0000);
    check("evt_err_sel",   a_err_sel,   2'b00);
    check("evt_hold_req",  a_hold_req,  1);
    check("evt_cap_valid_early", a_cap_valid, 0);
    check("evt_err_cnt",   a_err_cnt,   1);
    step();
    check("evt_cap_valid", a_cap_valid, 1);
    check("evt_hold_off",  a_hold_req,  0);
    check("evt_cap_stage", a_cap_stage, 2'b00);
    check("evt_cap_expc",  a_cap_expc,  64'hAAAA_AAAA_AAAA_AAAA);
    check("evt_cap_seen",  a_cap_seen,  64'h5555_5555_5555_5555);

    // Hit while HOLD waits for ack is counted but lost
    err_expc_in = 64'h1234_5678_9ABC_DEF0;
    err_seen_in = 64'h0FED_CBA9_8765_4321;
    set_hit(4'b0100, 4'b0100);
    step();
    set_hit(4'b0000, 4'b0000);
    check("hold_err_lost",  a_err_lost,  1);
    check("hold_err_cnt",   a_err_cnt,   2);
    check("hold_cap_expc",  a_cap_expc,  64'hAAAA_AAAA_AAAA_AAAA);
    check("hold_cap_valid", a_cap_valid, 1);

    // Ack re-arms; next hit (hdr1) is captured
    cap_ack = 1'b1;
    step();
    cap_ack = 1'b0;
    check("ack_cap_valid", a_cap_valid, 0);
    check("ack_busy",      a_busy,      0);
    set_hit(4'b0010, 4'b0010);
    step();
    set_hit(4'b0000, 4'b0000);
    check("rearm_err_sel", a_err_sel, 2'b01);
    check("rearm_err_cnt", a_err_cnt, 3);
    step();
    check("rearm_cap_stage", a_cap_stage, 2'b01);
    check("rearm_cap_expc",  a_cap_expc,  64'h1234_5678_9ABC_DEF0);

    // Clear in HOLD outranks a simultaneous hit
    clear = 1'b1;
    set_hit(4'b0001, 4'b0001);
    step();
    clear = 1'b0;
    set_hit(4'b0000, 4'b0000);
    check("clr_cap_valid", a_cap_valid, 0);
    check("clr_busy",      a_busy,      0);
    check("clr_err_cnt",   a_err_cnt,   0);
    check("clr_err_lost",  a_err_lost,  0);
    check("clr_cap_expc",  a_cap_expc,  0);
    check("clr_err_sel",   a_err_sel,   0);
    step();

    // Simultaneous hdr1/hdr2/data: hdr1 wins, all three counted, none lost
    set_hit(4'b1111, 4'b1110);
    step();
    set_hit(4'b0000, 4'b0000);
    check("multi_err_sel",  a_err_sel,  2'b01);
    check("multi_err_cnt",  a_err_cnt,  3);
    check("multi_err_lost", a_err_lost, 0);

    // Instance b: settle of 3 cycles, then stop on first
    arm = 1'b0; reset_n = 1'b0;
    step();
    reset_n = 1'b1; arm = 1'b1;
    err_expc_in = 64'hDEAD_BEEF_0000_1111;
    err_seen_in = 64'hCAFE_F00D_2222_3333;
    step();
    set_hit(4'b1000, 4'b1000);
    step();
    set_hit(4'b0000, 4'b0000);
    check("st3_hold_1",  b_hold_req, 1);
    check("st3_err_sel", b_err_sel,  2'b11);
    step();
    check("st3_hold_2",  b_hold_req,  1);
    check("st3_valid_2", b_cap_valid, 0);
    step();
    check("st3_hold_3",  b_hold_req,  1);
    step();
    check("st3_hold_off",  b_hold_req,  0);
    check("st3_cap_valid", b_cap_valid, 1);
    check("st3_cap_stage", b_cap_stage, 2'b11);
    check("st3_cap_expc",  b_cap_expc,  64'hDEAD_BEEF_0000_1111);
    check("st3_cap_seen",  b_cap_seen,  64'hCAFE_F00D_2222_3333);

    cap_ack = 1'b1;
    step();
    cap_ack = 1'b0;
    check("done_cap_valid", b_cap_valid, 0);
    check("done_busy",      b_busy,      1);
    check("done_cap_expc",  b_cap_expc,  64'hDEAD_BEEF_0000_1111);
    set_hit(4'b0001, 4'b0001);
    step();
    set_hit(4'b0000, 4'b0000);
    check("done_hold_req",  b_hold_req,  0);
    check("done_err_lost",  b_err_lost,  1);
    check("done_err_cnt",   b_err_cnt,   2);
    check("done_cap_stage", b_cap_stage, 2'b11);
    step();
    step();
    check("done_stays", b_busy, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("done_clr_busy", b_busy,     0);
    check("done_clr_cnt",  b_err_cnt,  0);
    check("done_clr_expc", b_cap_expc, 0);

    // Asynchronous reset in the middle of SELECT
    step();
    set_hit(4'b0001, 4'b0001);
    step();
    set_hit(4'b0000, 4'b0000);
    check("ars_pre_hold", b_hold_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("ars_hold_req", b_hold_req, 0);
    check("ars_busy",     b_busy,     0);
    check("ars_err_cnt",  b_err_cnt,  0);
    check("ars_err_sel",  b_err_sel,  0);
    check("ars_a_cnt",    a_err_cnt,  0);
    step();
    reset_n = 1'b1;

    // 20 single hits: 4-bit counter saturates at 15, 16-bit one reaches 20
    set_hit(4'b0001, 4'b0001);
    repeat (14) step();
    check("sat_cnt_14", b_err_cnt, 14);
    check("sat_flag_0", b_cnt_sat, 0);
    repeat (6) step();
    set_hit(4'b0000, 4'b0000);
    check("sat_cnt_15", b_err_cnt, 15);
    check("sat_flag_1", b_cnt_sat, 1);
    check("nosat_a_cnt", a_err_cnt, 20);
    check("nosat_a_flag", a_cnt_sat, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
